// File: rtl/lib_cpu_pkg.sv
// Shared CPU-side types; UART receive FSM state encoding.
package lib_cpu;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } UART_RX_STATE;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 LSB-first UART receiver with a one-byte valid/ack buffer.
// Bytes land in rx_data one cycle after the mid-stop-bit sample.
module uart_receiver
  import lib_cpu::*;
#(
  parameter int WAIT = 100_000_000 / 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int TW = $clog2(WAIT);
  // Timer counts down to zero, so a reload of N-1 spans N cycles.
  localparam logic [TW-1:0] T_FULL = TW'(WAIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(WAIT / 2 - 1);

  logic          rxs;
  UART_RX_STATE  state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          expired;
  logic          deliver;
  logic          frame_bad;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rxs)
  );

  assign expired = (timer == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RX_IDLE;
      timer   <= T_FULL;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_nx   = expired ? timer : timer - TW'(1);
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    deliver    = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rxs) begin
          state_nx = RX_START;
          timer_nx = T_HALF;
        end
      end
      RX_START: begin
        if (expired) begin
          timer_nx = T_FULL;
          if (!rxs) begin
            state_nx   = RX_DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (expired) begin
          shreg_nx = {rxs, shreg[7:1]};
          timer_nx = T_FULL;
          if (bit_idx == 3'd7) state_nx = RX_STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (expired) begin
          timer_nx = T_FULL;
          if (rxs) begin
            deliver  = 1'b1;
            state_nx = RX_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nx  = RX_RECOVER;
          end
        end
      end
      RX_RECOVER: begin
        // Hold off until the line returns high so a break is not decoded as 0x00s.
        if (rxs) begin
          state_nx = RX_IDLE;
          timer_nx = T_FULL;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= frame_bad;
      if (deliver) begin
        rx_valid <= 1'b1;
        if (!rx_valid || rx_ack) rx_data <= shreg;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
      // A new overrun outranks a simultaneous ack clearing the flag.
      if (deliver && rx_valid && !rx_ack) rx_overrun <= 1'b1;
      else if (rx_ack && rx_valid)        rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized and directed bench for uart_receiver against a byte-buffer model.
module tb_uart_receiver;

  localparam int WAIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_count = 0;
  int exp_fe   = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  uart_receiver #(.WAIT(WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_frame_err === 1'b1) fe_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_deliver(input logic [7:0] b, input logic ack);
    if (m_valid && !ack) begin
      m_ovr = 1'b1;
    end else begin
      m_data  = b;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"}, {24'h0, rx_data}, {24'h0, m_data});
    check({tag, ".valid"}, {31'h0, rx_valid}, {31'h0, m_valid});
    check({tag, ".ovr"}, {31'h0, rx_overrun}, {31'h0, m_ovr});
    check({tag, ".ferr"}, fe_count, exp_fe);
  endtask

  task automatic ack_pulse();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Start edge is driven at the first negedge; returns at the end of the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    @(negedge clk) uart_rx = 1'b0;
    repeat (WAIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (WAIT) @(negedge clk);
    end
    uart_rx = stop;
    repeat (WAIT + (stop ? 0 : extra_low)) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic good_frame(input string tag, input logic [7:0] b);
    send_frame(b, 1'b1, 0);
    model_deliver(b, 1'b0);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [7:0] b;
    logic bad;
    reset   = 1'b1;
    uart_rx = 1'b1;
    rx_ack  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model("reset_hold");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_model("reset_rel");

    // Single byte with latency measurement from the start edge.
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        @(negedge clk);
        while (rx_valid !== 1'b1 && lat < 150) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("single.latency", {31'h0, (lat >= 3 + WAIT / 2 + 9 * WAIT - 1) && (lat <= 3 + WAIT / 2 + 9 * WAIT + 1)}, 32'd1);
    model_deliver(8'h55, 1'b0);
    @(negedge clk);
    check_model("single");
    ack_pulse();
    check_model("single_ack");

    // Short low glitch must not start a frame.
    @(negedge clk) uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    check_model("glitch");
    good_frame("after_glitch", 8'hA5);
    ack_pulse();

    // Framing error followed by a held-low line.
    send_frame(8'hA3, 1'b0, 20);
    exp_fe++;
    repeat (5) @(negedge clk);
    check_model("frame_err");
    good_frame("after_ferr", 8'h3C);
    ack_pulse();

    // Overrun: second byte dropped, ack clears both flags.
    good_frame("ovr_first", 8'h11);
    good_frame("ovr_second", 8'h22);
    ack_pulse();
    check_model("ovr_ack");

    // Ack landing on the stop-sample cycle of the next byte.
    good_frame("sim_first", 8'h11);
    fork
      send_frame(8'h7E, 1'b1, 0);
      begin
        @(negedge clk);
        repeat (2 + WAIT / 2 + 9 * WAIT) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk) rx_ack = 1'b0;
      end
    join
    model_deliver(8'h7E, 1'b1);
    @(negedge clk);
    check_model("simultaneous");

    // Reset during data bit 4, with a full buffer and a pending overrun.
    good_frame("pre_reset", 8'h5A);
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        @(negedge clk);
        repeat (8 + 4 * WAIT + WAIT / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        exp_fe = fe_count;
        check_model("mid_reset");
        @(negedge clk) reset = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check_model("post_reset_idle");
    good_frame("after_reset", 8'h81);

    // Random bytes, random acks and occasional framing errors.
    for (int it = 0; it < 12; it++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (bad) begin
        send_frame(b, 1'b0, $urandom_range(0, 10));
        exp_fe++;
        repeat (5) @(negedge clk);
        check_model("rand_bad");
      end else begin
        good_frame("rand", b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
